// File: rtl/ram_pkg.sv
// Shared types and default widths for the three-port SDRAM arbiter.
package ram_pkg;

  localparam int AW_DEF = 25;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Values double as bit positions in the one-hot grant vector.
  typedef enum logic [1:0] {PORT_VID, PORT_DMA, PORT_CPU} port_t;

endpackage

// File: rtl/ram_arb_prio.sv
// Fixed-priority winner select (vid > dma > cpu) with a CPU starvation override.
module ram_arb_prio
  import ram_pkg::*;
(
  input  logic       vid_req_i,
  input  logic       dma_req_i,
  input  logic       cpu_req_i,
  input  logic       starved_i,
  output logic [2:0] grant_o
);

  // Video is never overridden; a starved CPU only jumps ahead of DMA.
  always_comb begin
    grant_o = 3'b000;
    if (vid_req_i)
      grant_o[PORT_VID] = 1'b1;
    else if (cpu_req_i && starved_i)
      grant_o[PORT_CPU] = 1'b1;
    else if (dma_req_i)
      grant_o[PORT_DMA] = 1'b1;
    else if (cpu_req_i)
      grant_o[PORT_CPU] = 1'b1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises video, DMA and CPU accesses onto one memory port with registered
// per-port acknowledge/read data and a DMA-ownership flag for the CPU's DMR input.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vid_req,
  input  logic [AW-1:0]   vid_addr,
  output logic [DW-1:0]   vid_dout,
  output logic            vid_ack,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW/8-1:0] dma_be,
  input  logic [DW-1:0]   dma_din,
  output logic [DW-1:0]   dma_dout,
  output logic            dma_ack,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW/8-1:0] cpu_be,
  input  logic [DW-1:0]   cpu_din,
  output logic [DW-1:0]   cpu_dout,
  output logic            cpu_ack,
  output logic            dma_owner,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout,
  input  logic            mem_ack
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t          state_q;
  port_t           grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   din_q, din_d;
  logic            mem_req_q;
  logic            vid_ack_q, dma_ack_q, cpu_ack_q;
  logic [DW-1:0]   vid_dout_q, dma_dout_q, cpu_dout_q;
  logic            dma_owner_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic [2:0]      win;
  logic            starved;

  assign starved = (starve_q == SW'(STARVE_MAX)) && cpu_req;

  ram_arb_prio u_prio (
    .vid_req_i (vid_req),
    .dma_req_i (dma_req),
    .cpu_req_i (cpu_req),
    .starved_i (starved),
    .grant_o   (win)
  );

  // Reads always use full byte enables; video is read-only.
  always_comb begin
    grant_d = PORT_CPU;
    addr_d  = cpu_addr;
    we_d    = cpu_we;
    be_d    = cpu_we ? cpu_be : '1;
    din_d   = cpu_din;
    if (win[PORT_VID]) begin
      grant_d = PORT_VID;
      addr_d  = vid_addr;
      we_d    = 1'b0;
      be_d    = '1;
      din_d   = '0;
    end else if (win[PORT_DMA]) begin
      grant_d = PORT_DMA;
      addr_d  = dma_addr;
      we_d    = dma_we;
      be_d    = dma_we ? dma_be : '1;
      din_d   = dma_din;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!cpu_req || win[PORT_CPU])
      starve_d = '0;
    else if (win[PORT_DMA] && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= PORT_VID;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      din_q       <= '0;
      mem_req_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_dout_q  <= '0;
      dma_dout_q  <= '0;
      cpu_dout_q  <= '0;
      dma_owner_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      vid_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (|win) begin
            state_q     <= BUSY;
            mem_req_q   <= 1'b1;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            din_q       <= din_d;
            dma_owner_q <= win[PORT_DMA];
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            case (grant_q)
              PORT_VID: begin
                vid_dout_q <= mem_dout;
                vid_ack_q  <= 1'b1;
              end
              PORT_DMA: begin
                dma_dout_q <= mem_dout;
                dma_ack_q  <= 1'b1;
              end
              default: begin
                cpu_dout_q <= mem_dout;
                cpu_ack_q  <= 1'b1;
              end
            endcase
          end
        end
        DONE: begin
          state_q     <= IDLE;
          dma_owner_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_din   = din_q;
  assign vid_ack   = vid_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_dout  = vid_dout_q;
  assign dma_dout  = dma_dout_q;
  assign cpu_dout  = cpu_dout_q;
  assign dma_owner = dma_owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a transaction-level model checked every cycle, plus
// directed scenarios with hand-computed cycle numbers and data.
module tb_ram_arbiter;

  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int BW   = DW / 8;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_dout;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [BW-1:0] dma_be;
  logic [DW-1:0] dma_din, dma_dout;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [BW-1:0] cpu_be;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic          dma_owner;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
    .dma_din(dma_din), .dma_dout(dma_dout), .dma_ack(dma_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_owner(dma_owner),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  bit            memAuto;
  int            memWait, memCnt;
  logic [DW-1:0] memData;
  int            vidLeft, dmaLeft, cpuLeft;

  // Model: one outstanding transaction record, plus the ack-cycle flag.
  bit            mTx, mAckCycle;
  int            mPort, mRun;
  logic [AW-1:0] mAddr;
  logic          mWe;
  logic [BW-1:0] mBe;
  logic [DW-1:0] mDin;
  logic [DW-1:0] mDout [3];

  typedef struct {
    int            cyc;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } memCmd_t;

  memCmd_t       memQ[$];
  int            ackPortQ[$];
  int            ackCycQ[$];
  logic [DW-1:0] ackDataQ[$];
  int            ownerQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Compare DUT outputs against the model and log observed events.
  task automatic checkAll();
    logic [2:0] eAck;
    logic       eReq;
    eReq = mTx && !mAckCycle;
    eAck = '0;
    if (mAckCycle) eAck[mPort] = 1'b1;
    checkOutput("mem_req", mem_req, eReq);
    checkOutput("vid_ack", vid_ack, eAck[0]);
    checkOutput("dma_ack", dma_ack, eAck[1]);
    checkOutput("cpu_ack", cpu_ack, eAck[2]);
    checkOutput("dma_owner", dma_owner, mTx && mPort == 1);
    checkOutput("vid_dout", vid_dout, mDout[0]);
    checkOutput("dma_dout", dma_dout, mDout[1]);
    checkOutput("cpu_dout", cpu_dout, mDout[2]);
    if (eReq) begin
      checkOutput("mem_addr", mem_addr, mAddr);
      checkOutput("mem_we", mem_we, mWe);
      checkOutput("mem_be", mem_be, mBe);
      if (mWe) checkOutput("mem_din", mem_din, mDin);
    end
    if (mem_req) memQ.push_back('{cyc, mem_we, mem_be, mem_addr, mem_din});
    if (vid_ack) begin ackPortQ.push_back(0); ackCycQ.push_back(cyc); ackDataQ.push_back(vid_dout); end
    if (dma_ack) begin ackPortQ.push_back(1); ackCycQ.push_back(cyc); ackDataQ.push_back(dma_dout); end
    if (cpu_ack) begin ackPortQ.push_back(2); ackCycQ.push_back(cyc); ackDataQ.push_back(cpu_dout); end
    if (dma_owner) ownerQ.push_back(cyc);
  endtask

  // Advance the model across one clock edge using the inputs that edge sees.
  task automatic updateModel();
    int port;
    if (reset) begin
      mTx = 0; mAckCycle = 0; mRun = 0;
      for (int i = 0; i < 3; i++) mDout[i] = '0;
    end else if (mAckCycle) begin
      mAckCycle = 0; mTx = 0;
    end else if (mTx) begin
      if (mem_ack) begin mAckCycle = 1; mDout[mPort] = mem_dout; end
    end else begin
      if (!cpu_req) mRun = 0;
      port = -1;
      if (vid_req) port = 0;
      else if (cpu_req && mRun >= SMAX) port = 2;
      else if (dma_req) port = 1;
      else if (cpu_req) port = 2;
      if (port >= 0) begin
        mTx = 1; mPort = port;
        case (port)
          0: begin mAddr = vid_addr; mWe = 0; mBe = '1; mDin = '0; end
          1: begin mAddr = dma_addr; mWe = dma_we; mBe = dma_we ? dma_be : '1; mDin = dma_din; end
          default: begin mAddr = cpu_addr; mWe = cpu_we; mBe = cpu_we ? cpu_be : '1; mDin = cpu_din; end
        endcase
        if (port == 2) mRun = 0;
        else if (port == 1 && cpu_req && mRun < SMAX) mRun++;
      end
    end
  endtask

  // Memory responder and requesters that drop req during their final ack cycle.
  task automatic driveEnv();
    if (memAuto) begin
      if (mem_req) begin
        if (memCnt == memWait) begin mem_ack = 1'b1; memCnt = 0; end
        else begin mem_ack = 1'b0; memCnt++; end
      end else begin
        mem_ack = 1'b0; memCnt = 0;
      end
    end
    mem_dout = memData;
    if (vid_ack) begin vidLeft--; if (vidLeft <= 0) vid_req = 1'b0; end
    if (dma_ack) begin dmaLeft--; if (dmaLeft <= 0) dma_req = 1'b0; end
    if (cpu_ack) begin cpuLeft--; if (cpuLeft <= 0) cpu_req = 1'b0; end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    cyc++;
    updateModel();
    #2;
    driveEnv();
  endtask

  task automatic idle(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic clearLogs();
    memQ.delete(); ackPortQ.delete(); ackCycQ.delete(); ackDataQ.delete(); ownerQ.delete();
  endtask

  task automatic waitAcks(input int n, input int budget, input string name);
    int k = 0;
    while (ackPortQ.size() < n && k < budget) begin stepCycle(); k++; end
    checkOutput(name, ackPortQ.size() >= n, 1'b1);
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [BW-1:0] be, input logic [DW-1:0] din, input int count);
    case (port)
      0: begin vid_addr = addr; vid_req = 1'b1; vidLeft = count; end
      1: begin dma_we = we; dma_addr = addr; dma_be = be; dma_din = din; dma_req = 1'b1; dmaLeft = count; end
      default: begin cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_din = din; cpu_req = 1'b1; cpuLeft = count; end
    endcase
  endtask

  initial begin
    int c, firstCpu, secondCpu;
    reset = 1'b1;
    vid_req = 0; vid_addr = '0; dma_req = 0; dma_we = 0; dma_addr = '0; dma_be = '0; dma_din = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_din = '0;
    mem_ack = 0; mem_dout = '0;
    memAuto = 1; memWait = 0; memCnt = 0; memData = '0;
    vidLeft = 0; dmaLeft = 0; cpuLeft = 0;
    mTx = 0; mAckCycle = 0; mPort = 0; mRun = 0; mAddr = '0; mWe = 0; mBe = '0; mDin = '0;
    for (int i = 0; i < 3; i++) mDout[i] = '0;

    idle(3);
    reset = 1'b0;
    idle(1);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_acks", {vid_ack, dma_ack, cpu_ack}, 3'b000);
    checkOutput("rst_dma_owner", dma_owner, 1'b0);
    checkOutput("rst_douts", {vid_dout, dma_dout, cpu_dout}, 48'h0);

    // Single CPU write with partial byte enables.
    clearLogs(); memWait = 0; memData = 16'h1111; c = cyc;
    applyStimulus(2, 1'b1, 25'h0001234, 2'b01, 16'hBEEF, 1);
    waitAcks(1, 20, "t1_timeout"); idle(4);
    checkOutput("t1_memreq_count", memQ.size(), 1);
    checkOutput("t1_ack_count", ackPortQ.size(), 1);
    if (memQ.size() >= 1) begin
      checkOutput("t1_memreq_cycle", memQ[0].cyc, c + 1);
      checkOutput("t1_mem_be", memQ[0].be, 2'b01);
      checkOutput("t1_mem_we", memQ[0].we, 1'b1);
      checkOutput("t1_mem_addr", memQ[0].addr, 25'h0001234);
      checkOutput("t1_mem_din", memQ[0].din, 16'hBEEF);
    end
    if (ackPortQ.size() >= 1) begin
      checkOutput("t1_ack_port", ackPortQ[0], 2);
      checkOutput("t1_ack_cycle", ackCycQ[0], c + 2);
    end

    // CPU read: partial be is ignored, full enables on the memory side.
    clearLogs(); memData = 16'hC3A1; c = cyc;
    applyStimulus(2, 1'b0, 25'h0000055, 2'b01, 16'h0000, 1);
    waitAcks(1, 20, "t1b_timeout"); idle(3);
    if (memQ.size() >= 1 && ackPortQ.size() >= 1) begin
      checkOutput("t1b_mem_be", memQ[0].be, 2'b11);
      checkOutput("t1b_cpu_dout", ackDataQ[0], 16'hC3A1);
      checkOutput("t1b_ack_cycle", ackCycQ[0], c + 2);
    end

    // All three requesters at once.
    clearLogs(); memData = 16'h0A0A; c = cyc;
    applyStimulus(0, 1'b0, 25'h0000100, 2'b11, 16'h0000, 1);
    applyStimulus(1, 1'b1, 25'h0000200, 2'b10, 16'h2222, 1);
    applyStimulus(2, 1'b1, 25'h0000300, 2'b11, 16'h3333, 1);
    waitAcks(3, 40, "t2_timeout"); idle(3);
    checkOutput("t2_ack_count", ackPortQ.size(), 3);
    checkOutput("t2_owner_cycles", ownerQ.size(), 2);
    if (ackPortQ.size() >= 3 && ownerQ.size() >= 1) begin
      checkOutput("t2_order", {ackPortQ[0][1:0], ackPortQ[1][1:0], ackPortQ[2][1:0]}, 6'b00_01_10);
      checkOutput("t2_vid_cycle", ackCycQ[0], c + 2);
      checkOutput("t2_dma_cycle", ackCycQ[1], c + 5);
      checkOutput("t2_cpu_cycle", ackCycQ[2], c + 8);
      checkOutput("t2_owner_first", ownerQ[0], c + 4);
    end

    // DMA streaming while CPU waits: starvation guard.
    clearLogs(); memData = 16'h4444; c = cyc;
    applyStimulus(1, 1'b0, 25'h0000400, 2'b11, 16'h0000, 1000);
    applyStimulus(2, 1'b0, 25'h0000500, 2'b11, 16'h0000, 2);
    waitAcks(18, 200, "t3_timeout");
    dma_req = 1'b0; dmaLeft = 0;
    idle(4);
    firstCpu = -1; secondCpu = -1;
    for (int i = 0; i < ackPortQ.size(); i++)
      if (ackPortQ[i] == 2) begin
        if (firstCpu < 0) firstCpu = i;
        else if (secondCpu < 0) secondCpu = i;
      end
    checkOutput("t3_dma_before_cpu", firstCpu, 8);
    checkOutput("t3_dma_between_cpu", secondCpu - firstCpu - 1, 8);
    if (ackCycQ.size() >= 18) begin
      checkOutput("t3_cpu1_cycle", ackCycQ[8], c + 26);
      checkOutput("t3_cpu2_cycle", ackCycQ[17], c + 53);
    end

    // Video read with four wait cycles.
    clearLogs(); memWait = 4; memData = 16'h5A5A; c = cyc;
    applyStimulus(0, 1'b0, 25'h0004000, 2'b00, 16'h0000, 1);
    waitAcks(1, 30, "t4_timeout"); idle(3);
    checkOutput("t4_memreq_cycles", memQ.size(), 5);
    if (memQ.size() >= 1 && ackPortQ.size() >= 1) begin
      checkOutput("t4_mem_we", memQ[0].we, 1'b0);
      checkOutput("t4_mem_be", memQ[0].be, 2'b11);
      checkOutput("t4_mem_addr", memQ[0].addr, 25'h0004000);
      checkOutput("t4_ack_port", ackPortQ[0], 0);
      checkOutput("t4_ack_cycle", ackCycQ[0], c + 6);
      checkOutput("t4_vid_dout", ackDataQ[0], 16'h5A5A);
    end
    memWait = 0;

    // Reset mid-transaction followed by a stale memory ack.
    clearLogs(); memAuto = 0; mem_ack = 1'b0; c = cyc;
    applyStimulus(2, 1'b1, 25'h0000042, 2'b11, 16'h1234, 1);
    stepCycle();
    reset = 1'b1; cpu_req = 1'b0; cpuLeft = 0;
    stepCycle();
    reset = 1'b0;
    stepCycle();
    memData = 16'hDEAD; mem_ack = 1'b1;
    stepCycle();
    mem_ack = 1'b0;
    idle(3);
    checkOutput("t5_no_ack", ackPortQ.size(), 0);
    checkOutput("t5_memreq_cycles", memQ.size(), 1);
    checkOutput("t5_cpu_dout_cleared", cpu_dout, 16'h0000);
    clearLogs(); memAuto = 1; memData = 16'h7E57; c = cyc;
    applyStimulus(2, 1'b0, 25'h0000077, 2'b11, 16'h0000, 1);
    waitAcks(1, 20, "t5_retry_timeout"); idle(3);
    if (ackPortQ.size() >= 1) begin
      checkOutput("t5_retry_port", ackPortQ[0], 2);
      checkOutput("t5_retry_cycle", ackCycQ[0], c + 2);
      checkOutput("t5_retry_data", ackDataQ[0], 16'h7E57);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
